// File: rtl/rb_result_collector_pkg.sv
// Shared reorder-buffer parameters, reserved index codes and the entry field layout.
// Imported by every rb_result_collector file.
package rb_result_collector_pkg;

  localparam int WORD_SIZE = 32;
  localparam int RB_SIZE   = 6;
  localparam int RB_INDEX  = 3;
  localparam int FU_NUM    = 4;
  localparam int REG_INDEX = 5;

  // Reserved index codes, never handed out by allocation
  localparam logic [RB_INDEX-1:0] NULL  = 3'd6;
  localparam logic [RB_INDEX-1:0] READY = 3'd7;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [REG_INDEX-1:0] dest_reg;
    logic [WORD_SIZE-1:0] value;
  } rb_entry_t;

  function automatic logic [RB_INDEX-1:0] rb_next(input logic [RB_INDEX-1:0] idx);
    if (idx == RB_INDEX'(RB_SIZE - 1)) begin
      rb_next = {RB_INDEX{1'b0}};
    end else begin
      rb_next = idx + {{(RB_INDEX-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/rb_result_collector_if.sv
// FU result bus (driven by the reservation stations) and the CDB snooped back by them.
interface rb_result_collector_if;
  import rb_result_collector_pkg::*;

  logic [FU_NUM*WORD_SIZE-1:0]  data_bus;
  logic [FU_NUM-1:0]            valid_bus;
  logic [FU_NUM*RB_INDEX-1:0]   RB_index_bus;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0]           CDB_data_valid;

  modport master (
    output data_bus, valid_bus, RB_index_bus,
    input  CDB_data_data, CDB_data_valid
  );

  modport slave (
    input  data_bus, valid_bus, RB_index_bus,
    output CDB_data_data, CDB_data_valid
  );

endinterface

// File: rtl/rb_result_collector_fu_select.sv
// rb_fu_select: combinational lowest-index FU match for one RB entry.
module rb_fu_select
  import rb_result_collector_pkg::*;
(
  input  logic [FU_NUM*WORD_SIZE-1:0] data_bus,
  input  logic [FU_NUM-1:0]           valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]  RB_index_bus,
  input  logic [RB_INDEX-1:0]         entry_idx,
  output logic                        hit,
  output logic [WORD_SIZE-1:0]        data
);

  // Scan from the highest FU down so the lowest matching FU is written last and wins
  always_comb begin
    hit  = 1'b0;
    data = {WORD_SIZE{1'b0}};
    for (int i = FU_NUM - 1; i >= 0; i--) begin
      if (valid_bus[i] && (RB_index_bus[i*RB_INDEX +: RB_INDEX] == entry_idx)) begin
        hit  = 1'b1;
        data = data_bus[i*WORD_SIZE +: WORD_SIZE];
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/rb_result_collector.sv
// Reorder-buffer result collector: allocate at issue, capture FU results, broadcast on CDB, retire in order.
// Optional macro RB_CDB_BYPASS_EN forwards same-cycle FU results onto the CDB combinationally.
module rb_result_collector
  import rb_result_collector_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_req,
  input  logic [REG_INDEX-1:0]    alloc_dest_reg,
  output logic                    alloc_grant,
  output logic [RB_INDEX-1:0]     alloc_index,
  rb_result_collector_if.slave    rb,
  output logic                    commit_valid,
  output logic [REG_INDEX-1:0]    commit_reg,
  output logic [WORD_SIZE-1:0]    commit_data,
  output logic [RB_INDEX-1:0]     commit_index,
  output logic [RB_INDEX:0]       count
);

  rb_entry_t                  entries_r [RB_SIZE];
  logic [RB_INDEX-1:0]        head_r;
  logic [RB_INDEX-1:0]        tail_r;
  logic [RB_INDEX:0]          count_r;
  logic [RB_SIZE-1:0]         hit_s;
  logic [WORD_SIZE-1:0]       hit_data_s [RB_SIZE];
  logic                       do_alloc_s;
  logic                       do_commit_s;
  logic [RB_SIZE-1:0]         cdb_valid_s;
  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data_s;

  for (genvar e = 0; e < RB_SIZE; e++) begin : g_sel
    rb_fu_select u_sel (
      .data_bus     (rb.data_bus),
      .valid_bus    (rb.valid_bus),
      .RB_index_bus (rb.RB_index_bus),
      .entry_idx    (RB_INDEX'(e)),
      .hit          (hit_s[e]),
      .data         (hit_data_s[e])
    );
  end

  // Grant looks only at the registered count, so a slot freed this edge is not reusable until the next
  assign alloc_grant = (count_r != (RB_INDEX+1)'(RB_SIZE));
  assign alloc_index = alloc_grant ? tail_r : NULL;
  assign do_alloc_s  = alloc_req & alloc_grant;
  assign do_commit_s = entries_r[head_r].busy & entries_r[head_r].done;
  assign count       = count_r;

  // Entry storage, pointers and the registered retire port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < RB_SIZE; e++) begin
        entries_r[e] <= {$bits(rb_entry_t){1'b0}};
      end
      head_r       <= {RB_INDEX{1'b0}};
      tail_r       <= {RB_INDEX{1'b0}};
      count_r      <= {(RB_INDEX+1){1'b0}};
      commit_valid <= 1'b0;
      commit_reg   <= {REG_INDEX{1'b0}};
      commit_data  <= {WORD_SIZE{1'b0}};
      commit_index <= NULL;
    end else begin
      for (int e = 0; e < RB_SIZE; e++) begin
        if (hit_s[e] && entries_r[e].busy) begin
          entries_r[e].value <= hit_data_s[e];
          entries_r[e].done  <= 1'b1;
        end
      end
      if (do_alloc_s) begin
        entries_r[tail_r].busy     <= 1'b1;
        entries_r[tail_r].done     <= 1'b0;
        entries_r[tail_r].dest_reg <= alloc_dest_reg;
        tail_r                     <= rb_next(tail_r);
      end
      // Retire clears the whole entry; placed after capture so it overrides a held-valid rewrite
      if (do_commit_s) begin
        entries_r[head_r] <= {$bits(rb_entry_t){1'b0}};
        commit_valid      <= 1'b1;
        commit_reg        <= entries_r[head_r].dest_reg;
        commit_data       <= entries_r[head_r].value;
        commit_index      <= head_r;
        head_r            <= rb_next(head_r);
      end else begin
        commit_valid      <= 1'b0;
      end
      case ({do_alloc_s, do_commit_s})
        2'b10:   count_r <= count_r + {{RB_INDEX{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{RB_INDEX{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // CDB view of every entry
  always_comb begin
    cdb_valid_s = {RB_SIZE{1'b0}};
    cdb_data_s  = {(WORD_SIZE*RB_SIZE){1'b0}};
    for (int e = 0; e < RB_SIZE; e++) begin
`ifdef RB_CDB_BYPASS_EN
      if (hit_s[e] && entries_r[e].busy) begin
        cdb_valid_s[e]                       = 1'b1;
        cdb_data_s[e*WORD_SIZE +: WORD_SIZE] = hit_data_s[e];
      end else begin
        cdb_valid_s[e]                       = entries_r[e].busy & entries_r[e].done;
        cdb_data_s[e*WORD_SIZE +: WORD_SIZE] = entries_r[e].value;
      end
`else
      cdb_valid_s[e]                       = entries_r[e].busy & entries_r[e].done;
      cdb_data_s[e*WORD_SIZE +: WORD_SIZE] = entries_r[e].value;
`endif
    end
  end

  assign rb.CDB_data_valid = cdb_valid_s;
  assign rb.CDB_data_data  = cdb_data_s;

endmodule

// File: tb/tb_rb_result_collector.sv
// Directed self-checking bench for rb_result_collector (default build, CDB bypass disabled).
module tb_rb_result_collector;
  import rb_result_collector_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 alloc_req;
  logic [REG_INDEX-1:0] alloc_dest_reg;
  logic                 alloc_grant;
  logic [RB_INDEX-1:0]  alloc_index;
  logic                 commit_valid;
  logic [REG_INDEX-1:0] commit_reg;
  logic [WORD_SIZE-1:0] commit_data;
  logic [RB_INDEX-1:0]  commit_index;
  logic [RB_INDEX:0]    count;

  int checks = 0;
  int errors = 0;

  rb_result_collector_if rb ();

  rb_result_collector dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_dest_reg (alloc_dest_reg),
    .alloc_grant    (alloc_grant),
    .alloc_index    (alloc_index),
    .rb             (rb),
    .commit_valid   (commit_valid),
    .commit_reg     (commit_reg),
    .commit_data    (commit_data),
    .commit_index   (commit_index),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_fu();
    rb.valid_bus    = '0;
    rb.data_bus     = '0;
    rb.RB_index_bus = '0;
  endtask

  task automatic drive_fu(input int fu, input logic [RB_INDEX-1:0] idx, input logic [WORD_SIZE-1:0] d);
    rb.valid_bus[fu]                         = 1'b1;
    rb.RB_index_bus[fu*RB_INDEX +: RB_INDEX] = idx;
    rb.data_bus[fu*WORD_SIZE +: WORD_SIZE]   = d;
  endtask

  task automatic do_reset();
    alloc_req = 1'b0;
    clear_fu();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [REG_INDEX-1:0] r);
    alloc_req      = 1'b1;
    alloc_dest_reg = r;
    step();
    alloc_req      = 1'b0;
  endtask

  task automatic check_commit(input string tag, input logic [REG_INDEX-1:0] r,
                              input logic [WORD_SIZE-1:0] d, input logic [RB_INDEX-1:0] idx);
    check_eq({tag, "_valid"}, 192'(commit_valid), 192'(1));
    check_eq({tag, "_reg"},   192'(commit_reg),   192'(r));
    check_eq({tag, "_data"},  192'(commit_data),  192'(d));
    check_eq({tag, "_index"}, 192'(commit_index), 192'(idx));
  endtask

  function automatic logic [WORD_SIZE-1:0] cdb_slice(input int e);
    cdb_slice = rb.CDB_data_data[e*WORD_SIZE +: WORD_SIZE];
  endfunction

  initial begin
    reset          = 1'b1;
    alloc_req      = 1'b0;
    alloc_dest_reg = '0;
    clear_fu();
    @(negedge clk);

    // Reset state
    check_eq("rst_count",        192'(count),             192'(0));
    check_eq("rst_commit_valid", 192'(commit_valid),      192'(0));
    check_eq("rst_commit_index", 192'(commit_index),      192'(6));
    check_eq("rst_cdb_valid",    192'(rb.CDB_data_valid), 192'(0));
    check_eq("rst_cdb_data",     192'(rb.CDB_data_data),  192'(0));
    check_eq("rst_grant",        192'(alloc_grant),       192'(1));
    reset = 1'b0;

    // Fill: indices 0..5, then full
    for (int i = 0; i < 6; i++) begin
      alloc_req      = 1'b1;
      alloc_dest_reg = 5'(i + 1);
      #1;
      check_eq($sformatf("fill_grant%0d", i), 192'(alloc_grant), 192'(1));
      check_eq($sformatf("fill_index%0d", i), 192'(alloc_index), 192'(i));
      step();
    end
    check_eq("full_grant", 192'(alloc_grant), 192'(0));
    check_eq("full_index", 192'(alloc_index), 192'(6));
    check_eq("full_count", 192'(count),       192'(6));
    step();
    check_eq("full_count_hold", 192'(count), 192'(6));
    alloc_req = 1'b0;

    // Single result then commit
    do_reset();
    alloc(5'd3);
    drive_fu(2, 3'd0, 32'h2A);
    step();
    clear_fu();
    check_eq("single_cdb_valid", 192'(rb.CDB_data_valid), 192'(6'b000001));
    check_eq("single_cdb_data",  192'(cdb_slice(0)),      192'(32'h2A));
    check_eq("single_no_commit", 192'(commit_valid),      192'(0));
    step();
    check_commit("single_commit", 5'd3, 32'h2A, 3'd0);
    check_eq("single_count", 192'(count), 192'(0));
    step();
    check_eq("single_pulse_end", 192'(commit_valid), 192'(0));
    check_eq("single_reg_hold",  192'(commit_reg),   192'(3));

    // Out-of-order completion, in-order retire
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    drive_fu(1, 3'd1, 32'd5);
    step();
    clear_fu();
    check_eq("ooo_cdb1",       192'(rb.CDB_data_valid), 192'(6'b000010));
    check_eq("ooo_no_commit1", 192'(commit_valid),      192'(0));
    drive_fu(0, 3'd0, 32'd9);
    step();
    clear_fu();
    check_eq("ooo_cdb2",       192'(rb.CDB_data_valid), 192'(6'b000011));
    check_eq("ooo_no_commit2", 192'(commit_valid),      192'(0));
    step();
    check_commit("ooo_c0", 5'd1, 32'd9, 3'd0);
    step();
    check_commit("ooo_c1", 5'd2, 32'd5, 3'd1);
    check_eq("ooo_count", 192'(count), 192'(0));
    step();
    check_eq("ooo_idle", 192'(commit_valid), 192'(0));

    // Priority, ignored targets and held valid
    do_reset();
    alloc(5'd7);
    alloc(5'd8);
    alloc(5'd9);
    drive_fu(0, 3'd2, 32'h11);
    drive_fu(3, 3'd2, 32'h22);
    drive_fu(1, 3'd6, 32'h66);
    drive_fu(2, 3'd4, 32'h55);
    step();
    check_eq("prio_data",     192'(cdb_slice(2)),      192'(32'h11));
    check_eq("prio_valid",    192'(rb.CDB_data_valid), 192'(6'b000100));
    check_eq("idle_ignored",  192'(cdb_slice(4)),      192'(0));
    step();
    clear_fu();
    check_eq("held_data",  192'(cdb_slice(2)), 192'(32'h11));
    check_eq("held_count", 192'(count),        192'(3));
    check_eq("held_nocmt", 192'(commit_valid), 192'(0));
    drive_fu(1, 3'd0, 32'hA0);
    drive_fu(2, 3'd1, 32'hB0);
    step();
    clear_fu();
    check_eq("prio_nocmt", 192'(commit_valid), 192'(0));
    step();
    check_commit("prio_c0", 5'd7, 32'hA0, 3'd0);
    step();
    check_commit("prio_c1", 5'd8, 32'hB0, 3'd1);
    step();
    check_commit("prio_c2", 5'd9, 32'h11, 3'd2);
    step();
    check_eq("prio_single", 192'(commit_valid), 192'(0));
    check_eq("prio_count",  192'(count),        192'(0));

    // Full plus commit on one edge: grant denied, then granted at wrapped tail
    do_reset();
    for (int i = 0; i < 6; i++) alloc(5'(i + 10));
    drive_fu(0, 3'd0, 32'h33);
    step();
    clear_fu();
    alloc_req      = 1'b1;
    alloc_dest_reg = 5'd20;
    #1;
    check_eq("wrap_denied", 192'(alloc_grant), 192'(0));
    step();
    check_commit("wrap_commit", 5'd10, 32'h33, 3'd0);
    check_eq("wrap_count5", 192'(count),       192'(5));
    check_eq("wrap_grant",  192'(alloc_grant), 192'(1));
    check_eq("wrap_index",  192'(alloc_index), 192'(0));
    step();
    alloc_req = 1'b0;
    check_eq("wrap_count6",  192'(count),        192'(6));
    check_eq("wrap_full",    192'(alloc_grant),  192'(0));
    check_eq("wrap_nocmt",   192'(commit_valid), 192'(0));

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1));
    drive_fu(0, 3'd1, 32'd1);
    drive_fu(1, 3'd2, 32'd2);
    step();
    clear_fu();
    check_eq("mid_cdb",   192'(rb.CDB_data_valid), 192'(6'b000110));
    check_eq("mid_count", 192'(count),             192'(4));
    reset = 1'b1;
    #1;
    check_eq("mid_rst_count",  192'(count),             192'(0));
    check_eq("mid_rst_cdbv",   192'(rb.CDB_data_valid), 192'(0));
    check_eq("mid_rst_cdbd",   192'(rb.CDB_data_data),  192'(0));
    check_eq("mid_rst_cidx",   192'(commit_index),      192'(6));
    check_eq("mid_rst_cdata",  192'(commit_data),       192'(0));
    @(posedge clk);
    #1;
    check_eq("mid_rst_nocmt",  192'(commit_valid),      192'(0));
    @(negedge clk);
    reset = 1'b0;
    alloc_req      = 1'b1;
    alloc_dest_reg = 5'd4;
    #1;
    check_eq("mid_post_index", 192'(alloc_index), 192'(0));
    step();
    alloc_req = 1'b0;
    check_eq("mid_post_count", 192'(count), 192'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rb_result_collector.md
Name: rb_result_collector

Overview:
- Reorder-buffer result side: allocates RB entries at issue, captures per-FU results from the FU result buses, broadcasts completed values on CDB_data, and retires entries in order to the register file.
- Consumes data_bus/valid_bus/RB_index_bus driven by the reservation stations.
- Produces CDB_data_data/CDB_data_valid, which the reservation stations snoop.

Parameters:
- WORD_SIZE, 32, datapath width.
- RB_SIZE, 6, number of RB entries (indices 0..RB_SIZE-1).
- RB_INDEX, 3, RB index width; the codes NULL=6 and READY=7 are reserved and never allocated.
- FU_NUM, 4, number of functional units on the result bus.
- REG_INDEX, 5, architectural register index width.

Ports:
- clk, in, 1, system clock (rising edge).
- reset, in, 1, asynchronous active-high reset.
- alloc_req, in, 1, issue stage requests one entry this cycle.
- alloc_dest_reg, in, REG_INDEX, destination register of the issuing instruction.
- alloc_grant, out, 1, combinational; 1 when not full.
- alloc_index, out, RB_INDEX, combinational; tail index, or NULL when full.
- data_bus, in, FU_NUM*WORD_SIZE, FU results; slice i belongs to FU i.
- valid_bus, in, FU_NUM, per-FU result valid.
- RB_index_bus, in, FU_NUM*RB_INDEX, per-FU destination entry.
- CDB_data_data, out, WORD_SIZE*RB_SIZE, per-entry value; slice e belongs to entry e.
- CDB_data_valid, out, RB_SIZE, per-entry "result ready".
- commit_valid, out, 1, one-cycle retire pulse.
- commit_reg, out, REG_INDEX, retired destination register.
- commit_data, out, WORD_SIZE, retired value.
- commit_index, out, RB_INDEX, retired entry index.
- count, out, RB_INDEX+1, number of occupied entries.

Behaviour:
- Storage:
  - Circular buffer with head, tail and count.
  - Each entry holds busy, done, dest_reg and value.
  - CDB_data_valid[e] = busy[e] & done[e].
  - CDB_data_data slice e = value[e].
- Reset (async):
  - All busy/done and values clear; head=tail=count=0.
  - commit_valid=0, commit_reg=0, commit_data=0, commit_index=NULL.
  - CDB_data_valid=0 and CDB_data_data=0.
  - Reset asserted mid-operation discards all in-flight entries; no commit pulse is emitted.
- Allocate:
  - alloc_grant = (count != RB_SIZE).
  - Allocation happens on a posedge where alloc_req & alloc_grant: entry[tail] gets busy=1, done=0, dest_reg=alloc_dest_reg; tail = (tail+1) mod RB_SIZE.
  - When full, the request is ignored with no side effects.
  - A freed slot is not reusable in the same cycle: full plus commit in the same edge still denies the grant.
- Capture, per edge, for each FU i with valid_bus[i]=1:
  - Take RB_INDEX slice e.
  - If e < RB_SIZE and busy[e]: value[e] = data slice i, done[e] = 1.
  - An out-of-range index, NULL, or an idle entry is ignored.
  - A valid held high over several edges rewrites the same value (idempotent).
  - Two FUs targeting the same entry on one edge: the lowest FU index wins.
- Commit:
  - On an edge where busy[head] & done[head]: commit_valid=1 and commit_reg/data/index load from head; entry clears; head advances mod RB_SIZE; count decrements.
  - Otherwise commit_valid=0 and the other commit outputs hold their last value.
  - At most one commit per cycle.
- Latency:
  - Result sampled at edge k appears on CDB_data_valid after edge k.
  - The earliest commit pulse is after edge k+1.
- Simultaneity:
  - Allocate and commit on the same edge: count is unchanged.
  - Capture into the head entry and commit of that entry are never in the same edge, because commit uses the registered done.
- Wrap-around: head and tail wrap from RB_SIZE-1 to 0. NULL and READY are never produced by alloc_index.

Optional Feature:
- RB_CDB_BYPASS_EN
- Defined:
  - CDB_data_valid[e] and slice e are additionally driven combinationally from any same-cycle valid FU result targeting busy entry e, using lowest-FU priority.
  - A snooping RS therefore sees the result one cycle earlier.
  - Commit timing is unchanged.
- Undefined: CDB outputs are purely registered, as described above.

Decomposition:
- The shared parameters include (already common to the RS blocks) supply WORD_SIZE, RB_SIZE, RB_INDEX, FU_NUM, REG_INDEX, NULL and READY.
- The entry field layout is added there.
- One natural sub-module: rb_fu_select, a combinational lowest-index FU match per entry (input: the three FU buses plus an entry index; output: hit and data). It is instantiated RB_SIZE times.

Test Plan:
- Reset then 6 alloc_req with dest_reg 1..6 -> alloc_index 0..5 and grants 1; 7th request -> alloc_grant=0, alloc_index=NULL, count=6.
- Alloc entry 0 (r3); FU2 drives valid, index 0, data 0x2A -> CDB_data_valid[0]=1 and slice 0=0x2A after that edge; next edge commit_valid=1, commit_reg=3, commit_data=0x2A, commit_index=0.
- Out-of-order completion: alloc 0 (r1) and 1 (r2); result for entry 1 (=5) first, then entry 0 (=9) -> commits in order: r1=9, then r2=5 on consecutive cycles.
- FU0 and FU3 both target entry 2 with 0x11 and 0x22 on the same edge -> value 0x11. valid_bus held 2 cycles -> a single done and a single commit.
- Fill to full, commit one while alloc_req=1 on the same edge -> grant denied that edge, granted next edge with alloc_index = wrapped tail 0.
- Assert reset with 4 entries busy and 2 done -> no commit pulse; all outputs return to reset values immediately; a subsequent alloc returns index 0.
